// File: rtl/clint_mtimer.sv
// clint_mtimer: memory-mapped RISC-V machine timer (mtime / mtimecmp).
//
// Sits on the LSU's MMIO request/response port. It accepts one request at a time
// and answers with a single-cycle latency. It drives a registered, level-sensitive
// timer interrupt whenever mtime >= mtimecmp, using an unsigned comparison.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid_i       request valid
//   req_ready_o       request accepted when valid & ready (only for in-range addresses)
//   req_wen_i         1 = write, 0 = read
//   req_addr_i        byte address
//   req_wdata_i       write data
//   req_wmask_i       byte strobes, bit i -> wdata[8i+7:8i]
//   addr_hit_o        combinational: address inside [BASE_ADDR, BASE_ADDR + 0xC000)
//   rsp_valid_o       response valid, held until rsp_ready_i
//   rsp_ready_i       response consumed when valid & ready
//   rsp_rdata_o       read data (0 for writes and errors)
//   rsp_err_o         unmapped or misaligned offset
//   timer_int_o       machine timer interrupt, level, registered
module clint_mtimer #(
  parameter logic [63:0] BASE_ADDR    = 64'h0200_0000,
  parameter logic [15:0] MTIMECMP_OFF = 16'h4000,
  parameter logic [15:0] MTIME_OFF    = 16'hBFF8,
  parameter int unsigned PRESCALE     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wmask_i,
  output logic        addr_hit_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        timer_int_o
);

  localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(PRESCALE - 1);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e            r_state;
  logic              r_rsp_valid;
  logic [63:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [63:0]       r_mtime;
  logic [63:0]       r_mtimecmp;
  logic [PrescW-1:0] r_presc;
  logic              r_timer_int;

  logic [63:0] w_offset;
  logic        w_hit;
  logic        w_misaligned;
  logic        w_sel_cmp;
  logic        w_sel_time;
  logic        w_err;
  logic        w_accept;
  logic        w_tick;
  logic        w_wr_cmp;
  logic        w_wr_time;
  logic [63:0] w_bitmask;
  logic [63:0] w_cmp_merged;
  logic [63:0] w_time_merged;
  logic [63:0] w_rdata;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign w_offset     = req_addr_i - BASE_ADDR;
  assign w_hit        = (req_addr_i >= BASE_ADDR) && (req_addr_i < BASE_ADDR + 64'hC000);
  assign w_misaligned = |req_addr_i[2:0];
  assign w_sel_cmp    = !w_misaligned && (w_offset == {48'd0, MTIMECMP_OFF});
  assign w_sel_time   = !w_misaligned && (w_offset == {48'd0, MTIME_OFF});
  assign w_err        = !(w_sel_cmp || w_sel_time);

  assign addr_hit_o  = w_hit;
  assign req_ready_o = (r_state == StIdle) && w_hit;
  assign w_accept    = req_valid_i && req_ready_o;

  // ---------------------------------------------------------------------------
  // Write merge and read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bitmask = '0;
    for (int i = 0; i < 8; i++) begin
      w_bitmask[8*i +: 8] = {8{req_wmask_i[i]}};
    end
  end

  assign w_cmp_merged  = (r_mtimecmp & ~w_bitmask) | (req_wdata_i & w_bitmask);
  assign w_time_merged = (r_mtime & ~w_bitmask) | (req_wdata_i & w_bitmask);

  // An all-zero mask is a successful no-op. It must not suppress the tick.
  assign w_wr_cmp  = w_accept && req_wen_i && w_sel_cmp && (|req_wmask_i);
  assign w_wr_time = w_accept && req_wen_i && w_sel_time && (|req_wmask_i);

  // Reads return the value held before this edge's update.
  always_comb begin
    w_rdata = '0;
    if (!req_wen_i) begin
      if (w_sel_cmp) begin
        w_rdata = r_mtimecmp;
      end else if (w_sel_time) begin
        w_rdata = r_mtime;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus FSM with registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state     <= StResp;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_err;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Timer registers
  // ---------------------------------------------------------------------------
  assign w_tick = (r_presc == PrescMax);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_timer_int <= 1'b0;
    end else begin
      // The prescaler runs independently of software writes to mtime.
      r_presc     <= w_tick ? '0 : r_presc + PrescW'(1);
      r_timer_int <= (r_mtime >= r_mtimecmp);
      // A software write to mtime wins over a coincident tick.
      if (w_wr_time) begin
        r_mtime <= w_time_merged;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (w_wr_cmp) begin
        r_mtimecmp <= w_cmp_merged;
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign timer_int_o = r_timer_int;

endmodule

// File: tb/tb_clint_mtimer.sv
// Self-checking bench for clint_mtimer.
// The main instance (PRESCALE=1) is compared on every cycle against a behavioural
// model. A second instance (PRESCALE=4) shares the inputs and pins the prescaler.
module tb_clint_mtimer;

  localparam logic [63:0] Base  = 64'h0200_0000;
  localparam logic [63:0] CmpA  = Base + 64'h4000;
  localparam logic [63:0] TimeA = Base + 64'hBFF8;
  localparam logic [63:0] AllF  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_ready;

  logic        req_ready, addr_hit, rsp_valid, rsp_err, timer_int;
  logic [63:0] rsp_rdata;
  logic        d4_req_ready, d4_addr_hit, d4_rsp_valid, d4_rsp_err, d4_timer_int;
  logic [63:0] d4_rsp_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;
  logic rnd_on = 1'b0;

  clint_mtimer #(.PRESCALE(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wen_i   (req_wen),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wmask_i (req_wmask),
    .addr_hit_o  (addr_hit),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .timer_int_o (timer_int)
  );

  clint_mtimer #(.PRESCALE(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (d4_req_ready),
    .req_wen_i   (req_wen),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wmask_i (req_wmask),
    .addr_hit_o  (d4_addr_hit),
    .rsp_valid_o (d4_rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (d4_rsp_rdata),
    .rsp_err_o   (d4_rsp_err),
    .timer_int_o (d4_timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model (PRESCALE=1: mtime advances on every edge)
  // ---------------------------------------------------------------------------
  logic [63:0] m_mtime, m_cmp, m_rdata;
  logic        m_int, m_busy, m_err;

  function automatic logic hit_f(input logic [63:0] a);
    return (a >= Base) && (a < Base + 64'hC000);
  endfunction

  // 0 = error, 1 = mtimecmp, 2 = mtime
  function automatic int kind_f(input logic [63:0] a);
    if (!hit_f(a) || a[2:0] != 3'd0) return 0;
    if (a == CmpA) return 1;
    if (a == TimeA) return 2;
    return 0;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_mtime <= '0;
      m_cmp   <= AllF;
      m_int   <= 1'b0;
      m_busy  <= 1'b0;
      m_rdata <= '0;
      m_err   <= 1'b0;
    end else begin
      m_int   <= (m_mtime >= m_cmp);
      m_mtime <= m_mtime + 64'd1;
      if (m_busy && rsp_ready) m_busy <= 1'b0;
      if (!m_busy && req_valid && hit_f(req_addr)) begin
        m_busy  <= 1'b1;
        m_err   <= (kind_f(req_addr) == 0);
        m_rdata <= req_wen ? 64'd0 :
                   (kind_f(req_addr) == 1) ? m_cmp :
                   (kind_f(req_addr) == 2) ? m_mtime : 64'd0;
        if (req_wen && kind_f(req_addr) == 1 && req_wmask != 8'd0)
          m_cmp <= merge(m_cmp, req_wdata, req_wmask);
        // Later assignment overrides the increment above: the write wins.
        if (req_wen && kind_f(req_addr) == 2 && req_wmask != 8'd0)
          m_mtime <= merge(m_mtime, req_wdata, req_wmask);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("addr_hit", 64'(addr_hit), 64'(hit_f(req_addr)));
      check("req_ready", 64'(req_ready), 64'(!m_busy && hit_f(req_addr)));
      check("rsp_valid", 64'(rsp_valid), 64'(m_busy));
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("rsp_err", 64'(rsp_err), 64'(m_err));
      check("timer_int", 64'(timer_int), 64'(m_int));
    end
  end

  // ---------------------------------------------------------------------------
  // One full transaction; call at a posedge, returns at the consuming posedge.
  // ---------------------------------------------------------------------------
  task automatic access(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] mask, output logic [63:0] rdata,
                        output logic err, output logic tint, output int acc);
    bit done;
    rdata = '0;
    err   = 1'b0;
    tint  = 1'b0;
    acc   = -1;
    #1;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1;
      @(posedge clk);
    end
    #1;
    req_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout addr %h: got no accept expected accept", addr);
      return;
    end
    acc = cyc;
    @(negedge clk);
    rdata = rsp_rdata;
    err   = rsp_err;
    tint  = timer_int;
    done  = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i != 0) @(negedge clk);
      if (rsp_valid && rsp_ready) done = 1;
      @(posedge clk);
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL consume_timeout addr %h: got no consume expected consume", addr);
    end
  endtask

  logic [63:0] rd;
  logic        er, ti;
  int          acc, w0;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset state, then 40 cycles of counting, read mtime in cycle 40.
    repeat (40) @(posedge clk);
    access(1'b0, TimeA, '0, 8'hFF, rd, er, ti, acc);
    check("t1_mtime_p1", rd, 64'd40);
    check("t1_err", 64'(er), 64'd0);
    check("t1_mtime_p4", d4_rsp_rdata, 64'd10);
    check("t1_err_p4", 64'(d4_rsp_err), 64'd0);

    // Wrap: FFFE written, read sees FFFF, next read is past 0 (0 then 1).
    access(1'b1, TimeA, AllF - 64'd1, 8'hFF, rd, er, ti, acc);
    access(1'b0, TimeA, '0, 8'hFF, rd, er, ti, acc);
    check("t3_pre_wrap", rd, AllF);
    check("t3_err", 64'(er), 64'd0);
    access(1'b0, TimeA, '0, 8'hFF, rd, er, ti, acc);
    check("t3_post_wrap", rd, 64'd1);

    // Write coincides with a tick: 0x100 plus the single tick since, not 0x102.
    access(1'b1, TimeA, 64'h100, 8'hFF, rd, er, ti, acc);
    access(1'b0, TimeA, '0, 8'hFF, rd, er, ti, acc);
    check("t4_write_wins", rd, 64'h101);

    // Interrupt rises the cycle after mtime reaches 20; falls 2 edges after cmp write.
    access(1'b1, TimeA, 64'd0, 8'hFF, rd, er, ti, w0);
    access(1'b1, CmpA, 64'd20, 8'hFF, rd, er, ti, acc);
    while (cyc < w0 + 20) @(negedge clk);
    check("t2_int_low", 64'(timer_int), 64'd0);
    @(negedge clk);
    check("t2_int_high", 64'(timer_int), 64'd1);
    @(posedge clk);
    access(1'b1, CmpA, AllF, 8'hFF, rd, er, ti, acc);
    check("t2_int_after_1", 64'(ti), 64'd1);
    @(negedge clk);
    check("t2_int_after_2", 64'(timer_int), 64'd0);
    @(posedge clk);

    // Backpressure: response held 5 cycles, no new accept.
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = TimeA; req_wmask = 8'hFF;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("t5_hold_valid", 64'(rsp_valid), 64'd1);
      check("t5_hold_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_done", 64'(rsp_valid), 64'd0);
    @(posedge clk);

    // Reset in the middle of a write response.
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = CmpA; req_wdata = 64'd5; req_wmask = 8'hFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_valid", 64'(rsp_valid), 64'd0);
    check("t5_rst_int", 64'(timer_int), 64'd0);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    access(1'b0, CmpA, '0, 8'hFF, rd, er, ti, acc);
    check("t5_cmp_reset", rd, AllF);

    // Error decode and partial masks.
    access(1'b0, Base + 64'h8, '0, 8'hFF, rd, er, ti, acc);
    check("t6_bad_err", 64'(er), 64'd1);
    check("t6_bad_rdata", rd, 64'd0);
    access(1'b0, TimeA + 64'd4, '0, 8'hFF, rd, er, ti, acc);
    check("t6_misalign_err", 64'(er), 64'd1);
    access(1'b1, CmpA, 64'h1234_5678_9ABC_DEF0, 8'h0F, rd, er, ti, acc);
    access(1'b0, CmpA, '0, 8'hFF, rd, er, ti, acc);
    check("t6_mask_lo", rd, 64'hFFFF_FFFF_9ABC_DEF0);
    access(1'b1, TimeA, 64'd7, 8'h00, rd, er, ti, acc);
    check("t6_mask0_err", 64'(er), 64'd0);
    #1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = Base + 64'hC000;
    repeat (4) begin
      @(negedge clk);
      check("t6_out_hit", 64'(addr_hit), 64'd0);
      check("t6_out_valid", 64'(rsp_valid), 64'd0);
    end
    #1;
    req_addr = Base - 64'd8;
    @(negedge clk);
    check("t6_below_hit", 64'(addr_hit), 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);

    // Randomized traffic with random response backpressure.
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #1;
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int n = 0; n < 300; n++) begin
      int unsigned sel;
      logic [63:0] a, d;
      logic [7:0] m;
      sel = $urandom_range(0, 10);
      case (sel)
        0, 1, 2, 3: a = CmpA;
        4, 5, 6, 7: a = TimeA;
        8:          a = Base + {45'd0, 16'($urandom_range(0, 16'h17FF)), 3'd0};
        9:          a = (($urandom_range(0, 1) != 0) ? CmpA : TimeA) + 64'($urandom_range(1, 7));
        default:    a = ($urandom_range(0, 1) != 0) ? Base + 64'hC000 + 64'($urandom_range(0, 64))
                                                     : Base - 64'($urandom_range(1, 64));
      endcase
      d = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom}
                                       : m_mtime + 64'($urandom_range(0, 40)) - 64'd20;
      m = ($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom);
      if (!hit_f(a)) begin
        #1;
        req_valid = 1'b1; req_wen = $urandom_range(0, 1) != 0; req_addr = a;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
      end else begin
        access($urandom_range(0, 1) != 0, a, d, m, rd, er, ti, acc);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rnd_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
